// File: rtl/finn_axis_pkg.sv
`default_nettype none
// ============================================================================
// finn_axis_pkg : shared types, sizing helpers and tkeep helper for AXIS blocks
// Revision: 1.0
// ============================================================================
package finn_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } axis_src_state_t;

  localparam int unsigned DEFAULT_TDATA_WIDTH = 512;
  localparam int unsigned DEFAULT_WORD_WIDTH  = 32;
  localparam int unsigned MAX_KEEP_WIDTH      = 128;

  function automatic int unsigned axis_bytes(input int unsigned width);
    return width / 8;
  endfunction

  function automatic int unsigned axis_lanes(input int unsigned width, input int unsigned word);
    return width / word;
  endfunction

  localparam int unsigned BYTES = axis_bytes(DEFAULT_TDATA_WIDTH);
  localparam int unsigned LANES = axis_lanes(DEFAULT_TDATA_WIDTH, DEFAULT_WORD_WIDTH);

  // Byte enables of the final beat; callers truncate to their own keep width.
  function automatic logic [MAX_KEEP_WIDTH-1:0] last_keep(input logic [31:0] len,
                                                          input int unsigned bytes);
    logic [31:0]               rem;
    logic [MAX_KEEP_WIDTH-1:0] full;
    rem = len % bytes;
    if (bytes >= MAX_KEEP_WIDTH) full = '1;
    else full = (MAX_KEEP_WIDTH'(1) << bytes) - MAX_KEEP_WIDTH'(1);
    if (rem == 32'd0) return full;
    return (MAX_KEEP_WIDTH'(1) << rem) - MAX_KEEP_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/finn_axis_pattern_lanes.sv
`default_nettype none
// ============================================================================
// finn_axis_pattern_lanes : combinational base-word to full-beat pattern expander
// Revision: 1.0
// ============================================================================
module finn_axis_pattern_lanes
  import finn_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic [31:0]           base,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int NUM_LANES = int'(axis_lanes(DATA_WIDTH, WORD_WIDTH));

  // Lane 0 sits in the LSBs; each lane is base + index, wrapping at 2^32.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [31:0] sum;
    assign sum = base + 32'(i);
    assign data[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(sum);
  end

endmodule
`default_nettype wire

// File: rtl/finn_axis_pattern_source.sv
`default_nettype none
// ============================================================================
// finn_axis_pattern_source : run-time configurable AXI4-Stream pattern transmitter
// Revision: 1.0
// ============================================================================
module finn_axis_pattern_source
  import finn_axis_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_WORD_WIDTH         = 32
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              ctrl_start,
  input  logic [31:0]                       ctrl_xfer_size_in_bytes,
  input  logic [31:0]                       ctrl_seed,
  output logic                              ctrl_busy,
  output logic                              ctrl_done,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                              m_axis_tlast
);

  localparam int AXIS_BYTES = int'(axis_bytes(C_M_AXIS_TDATA_WIDTH));
  localparam int AXIS_LANES = int'(axis_lanes(C_M_AXIS_TDATA_WIDTH, C_WORD_WIDTH));

  axis_src_state_t                   state, state_next;
  logic [31:0]                       len_reg, len_next;
  logic [31:0]                       base, base_next;
  logic [32:0]                       remaining, remaining_next;
  logic [32:0]                       start_beats;
  logic                              valid_next, last_next, busy_next, done_next;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   data_next, lane_data;
  logic [AXIS_BYTES-1:0]             keep_next, start_last_keep, held_last_keep;
  logic [31:0]                       lane_base;

  // 33-bit so that a 0xFFFFFFFF length cannot overflow the rounding add.
  assign start_beats = ({1'b0, ctrl_xfer_size_in_bytes} + 33'(AXIS_BYTES - 1)) / 33'(AXIS_BYTES);
  assign start_last_keep = AXIS_BYTES'(last_keep(ctrl_xfer_size_in_bytes, AXIS_BYTES));
  assign held_last_keep  = AXIS_BYTES'(last_keep(len_reg, AXIS_BYTES));
  assign lane_base       = (state == IDLE) ? ctrl_seed : base;

  finn_axis_pattern_lanes #(
    .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH),
    .WORD_WIDTH (C_WORD_WIDTH)
  ) u_lanes (
    .base (lane_base),
    .data (lane_data)
  );

  always_comb begin
    state_next     = state;
    len_next       = len_reg;
    base_next      = base;
    remaining_next = remaining;
    valid_next     = m_axis_tvalid;
    data_next      = m_axis_tdata;
    keep_next      = m_axis_tkeep;
    last_next      = m_axis_tlast;
    busy_next      = ctrl_busy;
    done_next      = ctrl_done;
    unique case (state)
      IDLE: begin
        if (ctrl_start) begin
          len_next  = ctrl_xfer_size_in_bytes;
          busy_next = 1'b1;
          if (ctrl_xfer_size_in_bytes == 32'd0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next     = SEND;
            valid_next     = 1'b1;
            data_next      = lane_data;
            base_next      = ctrl_seed + 32'(AXIS_LANES);
            remaining_next = start_beats;
            last_next      = (start_beats == 33'd1);
            keep_next      = (start_beats == 33'd1) ? start_last_keep : '1;
          end
        end
      end
      SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (remaining == 33'd1) begin
            state_next     = DONE;
            valid_next     = 1'b0;
            last_next      = 1'b0;
            done_next      = 1'b1;
            remaining_next = '0;
          end else begin
            data_next      = lane_data;
            base_next      = base + 32'(AXIS_LANES);
            remaining_next = remaining - 33'd1;
            last_next      = (remaining == 33'd2);
            keep_next      = (remaining == 33'd2) ? held_last_keep : '1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        done_next  = 1'b0;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= IDLE;
      len_reg       <= '0;
      base          <= '0;
      remaining     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      ctrl_busy     <= 1'b0;
      ctrl_done     <= 1'b0;
    end else begin
      state         <= state_next;
      len_reg       <= len_next;
      base          <= base_next;
      remaining     <= remaining_next;
      m_axis_tvalid <= valid_next;
      m_axis_tdata  <= data_next;
      m_axis_tkeep  <= keep_next;
      m_axis_tlast  <= last_next;
      ctrl_busy     <= busy_next;
      ctrl_done     <= done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_finn_axis_pattern_source.sv
`default_nettype none
// ============================================================================
// tb_finn_axis_pattern_source : directed table-driven bench for the pattern source
// Revision: 1.0
// ============================================================================
module tb_finn_axis_pattern_source;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   xfer_len;
  logic [31:0]   seed;
  logic          busy, done, tvalid, tready, tlast;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] len;
    logic [31:0] seed;
    int          beats;
    logic [63:0] keep;
    int          done_cyc;
  } vec_t;

  vec_t tbl [6];

  finn_axis_pattern_source #(
    .C_M_AXIS_TDATA_WIDTH (DW),
    .C_WORD_WIDTH         (32)
  ) dut (
    .ap_clk                  (clk),
    .ap_rst_n                (rst_n),
    .ctrl_start              (start),
    .ctrl_xfer_size_in_bytes (xfer_len),
    .ctrl_seed               (seed),
    .ctrl_busy               (busy),
    .ctrl_done               (done),
    .m_axis_tvalid           (tvalid),
    .m_axis_tready           (tready),
    .m_axis_tdata            (tdata),
    .m_axis_tkeep            (tkeep),
    .m_axis_tlast            (tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_beat(input logic [31:0] s, input int b);
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = s + 32'(b * 16) + 32'(i);
    return v;
  endfunction

  // Runs one transfer from the current (IDLE) cycle; returns in the cycle after done.
  task automatic run_xfer(input logic [31:0] len, input logic [31:0] s, input int exp_beats,
                          input logic [63:0] exp_keep, input int exp_done,
                          input bit rnd, input bit restart);
    int  cyc;
    int  b;
    int  done_cyc;
    bit  hs;
    start    = 1'b1;
    xfer_len = len;
    seed     = s;
    step();
    start    = 1'b0;
    xfer_len = 32'hDEAD_0001;
    seed     = 32'hBEEF_0000;
    cyc      = 1;
    b        = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 400) begin
      if (tvalid) begin
        if (b >= exp_beats) begin
          check("extra_beat", 1, 0);
        end else begin
          check("tdata", tdata, model_beat(s, b));
          check("tkeep", tkeep, (b == exp_beats - 1) ? exp_keep : 64'hFFFF_FFFF_FFFF_FFFF);
          check("tlast", tlast, (b == exp_beats - 1));
        end
      end
      check("busy_during", busy, 1);
      if (done) done_cyc = cyc;
      start  = restart && (cyc == 1);
      xfer_len = restart ? 32'd4096 : xfer_len;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs     = tvalid && tready;
      step();
      if (hs) b++;
      cyc++;
    end
    start  = 1'b0;
    tready = 1'b1;
    check("done_seen", (done_cyc >= 0), 1);
    if (exp_done > 0) check("done_cycle", done_cyc, exp_done);
    check("beat_count", b, exp_beats);
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("valid_after", tvalid, 0);
  endtask

  initial begin
    tbl[0] = '{len: 32'd128,  seed: 32'h0,        beats: 2,  keep: 64'hFFFF_FFFF_FFFF_FFFF, done_cyc: 3};
    tbl[1] = '{len: 32'd100,  seed: 32'h10,       beats: 2,  keep: 64'h0000_000F_FFFF_FFFF, done_cyc: 3};
    tbl[2] = '{len: 32'd0,    seed: 32'h1234,     beats: 0,  keep: 64'hFFFF_FFFF_FFFF_FFFF, done_cyc: 1};
    tbl[3] = '{len: 32'd1,    seed: 32'h5,        beats: 1,  keep: 64'h1,                   done_cyc: 2};
    tbl[4] = '{len: 32'd65,   seed: 32'h7,        beats: 2,  keep: 64'h1,                   done_cyc: 3};
    tbl[5] = '{len: 32'd4095, seed: 32'hABCD_0000, beats: 64, keep: 64'h7FFF_FFFF_FFFF_FFFF, done_cyc: 65};

    rst_n    = 1'b0;
    start    = 1'b0;
    xfer_len = '0;
    seed     = '0;
    tready   = 1'b1;
    step();
    step();
    check("rst_valid", tvalid, 0);
    check("rst_last",  tlast, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_data",  tdata, '0);
    check("rst_keep",  tkeep, '0);
    rst_n = 1'b1;
    step();

    // Table entries run back-to-back: each start lands in the cycle after done.
    for (int k = 0; k < 6; k++)
      run_xfer(tbl[k].len, tbl[k].seed, tbl[k].beats, tbl[k].keep, tbl[k].done_cyc, 1'b0, 1'b0);

    run_xfer(32'd256, 32'h1000, 4, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b1, 1'b0);

    // Wrapping seed with a second start pulse while busy.
    run_xfer(32'd64, 32'hFFFF_FFF8, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 1'b1);
    step();
    check("restart_ignored_busy", busy, 0);
    check("restart_ignored_valid", tvalid, 0);

    // Asynchronous reset mid-cycle while beat 2 of 4 is presented.
    start    = 1'b1;
    xfer_len = 32'd256;
    seed     = 32'h300;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_data", tdata, model_beat(32'h300, 2));
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", tvalid, 0);
    check("async_last",  tlast, 0);
    check("async_busy",  busy, 0);
    check("async_data",  tdata, '0);
    check("async_keep",  tkeep, '0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle", busy, 0);
    run_xfer(32'd64, 32'h55, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/finn_axis_pattern_source.md
# finn_axis_pattern_source

Run-time-configurable AXI4-Stream transmitter that produces the input stream for the stream kernels (vadd example and successors). It sits upstream of a kernel's slave stream port and drives a deterministic word pattern of a programmed byte length, with correct `tkeep`/`tlast` on the final beat. On-chip loopback tests and hardware bring-up use it with no host traffic.

## Interface
- `C_M_AXIS_TDATA_WIDTH`, 512: stream data width in bits; multiple of 32, at most 1024.
- `C_WORD_WIDTH`, 32: pattern lane width in bits; divides `C_M_AXIS_TDATA_WIDTH`.

Ports:
- `ap_clk`  in  1  sole clock, all logic rising-edge.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `ctrl_start`  in  1  one-cycle start pulse; ignored while busy.
- `ctrl_xfer_size_in_bytes`  in  32  transfer length, sampled on accepted start.
- `ctrl_seed`  in  32  first pattern word, sampled on accepted start.
- `ctrl_busy`  out  1  high from accepted start until the done cycle, inclusive.
- `ctrl_done`  out  1  one-cycle completion pulse.
- `m_axis_tvalid`  out  1  AXIS valid.
- `m_axis_tready`  in  1  AXIS ready.
- `m_axis_tdata`  out  `C_M_AXIS_TDATA_WIDTH`  pattern data.
- `m_axis_tkeep`  out  `C_M_AXIS_TDATA_WIDTH/8`  byte enables.
- `m_axis_tlast`  out  1  final beat marker.

## Operation
- Constants: BYTES = width/8, LANES = width/`C_WORD_WIDTH`. Beat count = ceil(len/BYTES), computed in 33 bits with no overflow at len = 0xFFFFFFFF.
- FSM states:
  - IDLE -> SEND on `ctrl_start` with len > 0.
  - IDLE -> DONE on `ctrl_start` with len = 0.
  - SEND -> DONE on the handshake of the last beat.
  - DONE -> IDLE unconditionally.
- Pattern: lane i of beat b = seed + b·LANES + i, modulo 2^32. Lane 0 occupies the LSBs. Lanes whose bytes are disabled still carry the pattern value.
- `tkeep`: all ones except on the last beat, where it is ((1 << (len mod BYTES)) − 1); when len mod BYTES = 0 it is all ones.
- `tlast` is high only on the last beat.
- AXIS rules:
  - Once `tvalid` rises, `tvalid`, `tdata`, `tkeep` and `tlast` stay stable until `tvalid && tready`.
  - `tvalid` never depends combinationally on `tready`.
  - Outputs are registered, with no combinational path from `tready` to any output.
- `ctrl_start` during SEND or DONE is dropped; the latched length and seed are unchanged.
- Length and seed are latched at start; input changes mid-transfer have no effect.
- Asynchronous reset at any point:
  - All outputs go to 0 immediately and the FSM returns to IDLE.
  - A partial transfer is abandoned; there is no resume.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `ctrl_busy` and `ctrl_done` are 0; `m_axis_tdata` and `m_axis_tkeep` are all zeros.
- Start accepted in cycle 0 -> `ctrl_busy` = 1 and `m_axis_tvalid` = 1 with beat 0 in cycle 1.
- With `tready` held high, one beat per cycle, no bubbles: N beats occupy cycles 1..N.
- Next beat appears the cycle after each handshake.
- `ctrl_done` pulses the cycle after the last handshake; `ctrl_busy` falls the cycle after that.
- len = 0: `ctrl_done` in cycle 1, no `tvalid` ever asserted.
- Back-to-back: a start in the cycle after `ctrl_done`'s cycle (IDLE) is accepted.

## Structure
- Shared package `finn_axis_pkg`:
  - state enum `axis_src_state_t` (IDLE, SEND, DONE);
  - localparams BYTES and LANES as functions of width;
  - function `last_keep(len, bytes)`.
  - Future stream sinks and checkers reuse this package.
- One sub-module, `finn_axis_pattern_lanes`: combinational generator from base word to full `tdata` (LANES parallel adders). It is registered by the parent.
- Parent holds the FSM, the 33-bit beats-remaining down-counter, the base-word register (advances by LANES per handshake) and the output register stage.

## Test plan
Defaults: 512-bit width, BYTES = 64, LANES = 16.
- len = 128, seed = 0, `tready` = 1:
  - beat 0 lanes = 0..15, beat 1 lanes = 16..31;
  - `tkeep` = all ones, `tlast` on beat 1 only;
  - `ctrl_done` in cycle 3.
- len = 100, seed = 0x10: 2 beats; last `tkeep` = 0x0000000FFFFFFFFF (36 bytes); beat 1 lane 0 = 0x20.
- len = 256 with `tready` random (50%): data and `tlast` stable across every stall; 4 beats in order; no beat lost or duplicated.
- len = 0: `tvalid` never high; `ctrl_done` pulses cycle 1; `ctrl_busy` high in cycle 1 only.
- seed = 0xFFFFFFF8, len = 64: lanes = 0xFFFFFFF8..0xFFFFFFFF, then 0x0..0x7 (wrap); a second `ctrl_start` mid-transfer is ignored.
- `ap_rst_n` low during beat 2 of 4 (asynchronous, mid-cycle): all outputs 0 before the next edge; a new start after release yields beat 0 = seed.
